// File: rtl/fifo_rd_packer_pkg.sv
// Shared types and helpers for the async-FIFO read-side packer.
package fifo_rd_pkg;

   typedef enum logic {
      OUT_EMPTY,
      OUT_FULL
   } out_state_t;

   function automatic int unsigned lane_cnt_w(input int unsigned lanes);
      return (lanes > 1) ? $clog2(lanes) : 1;
   endfunction

   // Mask with the low n bits set; callers truncate to their lane count.
   function automatic logic [31:0] keep_mask(input int unsigned n);
      logic [31:0] m;
      m = '0;
      for (int unsigned i = 0; i < 32; i++)
         if (i < n) m[i] = 1'b1;
      return m;
   endfunction

endpackage

// File: rtl/fifo_rd_packer_if.sv
// FIFO show-ahead read port plus the packed valid/ready output stream.
interface fifo_rd_packer_if #(
   parameter int unsigned DSIZE = 8,
   parameter int unsigned LANES = 4
);
   logic                     rempty;
   logic [DSIZE-1:0]         rdata;
   logic                     rinc;
   logic                     out_valid;
   logic                     out_ready;
   logic [DSIZE*LANES-1:0]   out_data;
   logic [LANES-1:0]         out_keep;

   modport master (
      input  rempty, rdata, out_ready,
      output rinc, out_valid, out_data, out_keep
   );

   modport slave (
      output rempty, rdata, out_ready,
      input  rinc, out_valid, out_data, out_keep
   );
endinterface

// File: rtl/fifo_rd_packer_idle_timer.sv
// Saturating idle counter; expire holds while the count sits at MAX.
module fifo_rd_idle_timer #(
   parameter int unsigned MAX = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic inc,
   input  logic clr,
   output logic expire
);
   localparam int unsigned W = $clog2(MAX + 1);

   logic [W-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count <= '0;
      else if (clr)
         count <= '0;
      else if (inc && (count != W'(MAX)))
         count <= count + W'(1);
   end

   assign expire = (count == W'(MAX));
endmodule

// File: rtl/fifo_rd_packer.sv
// Packs LANES consecutive FIFO entries into one output word (lane 0 = oldest).
// FIFO_RDR_FLUSH_EN adds an idle-timeout flush of partially packed words.
module fifo_rd_packer
   import fifo_rd_pkg::*;
#(
   parameter int unsigned DSIZE    = 8,
   parameter int unsigned LANES    = 4,
   parameter int unsigned IDLE_MAX = 15
) (
   input  logic             rclk,
   input  logic             rrst_n,
   fifo_rd_packer_if.master bus
);
   localparam int unsigned    CW   = lane_cnt_w(LANES);
   localparam logic [CW-1:0]  LAST = CW'(LANES - 1);

   out_state_t                     state, state_nxt;
   logic [CW-1:0]                  cnt;
   logic [LANES-2:0][DSIZE-1:0]    acc;
   logic                           load;
   logic                           final_cap;

   assign bus.out_valid = (state == OUT_FULL);

   // Only the final lane needs the output register free; earlier lanes land in acc.
   assign bus.rinc = rrst_n && !bus.rempty &&
                     !((cnt == LAST) && bus.out_valid && !bus.out_ready);

   assign final_cap = bus.rinc && (cnt == LAST);

`ifdef FIFO_RDR_FLUSH_EN
   logic                           expire;
   logic                           flush_fire;
   logic [LANES-2:0][DSIZE-1:0]    acc_masked;

   fifo_rd_idle_timer #(
      .MAX (IDLE_MAX)
   ) u_idle_timer (
      .clk    (rclk),
      .rst_n  (rrst_n),
      .inc    ((cnt != '0) && bus.rempty),
      .clr    (bus.rinc || flush_fire),
      .expire (expire)
   );

   assign flush_fire = expire && !bus.rinc && (cnt != '0) &&
                       (!bus.out_valid || bus.out_ready);

   // acc lanes at or above cnt may hold stale data from an earlier word.
   always_comb begin
      acc_masked = '0;
      for (int unsigned i = 0; i < LANES - 1; i++)
         if (i < 32'(cnt)) acc_masked[i] = acc[i];
   end

   assign load = final_cap || flush_fire;
`else
   assign load = final_cap;
`endif

   always_comb begin
      state_nxt = state;
      unique case (state)
         OUT_EMPTY: if (load) state_nxt = OUT_FULL;
         OUT_FULL:  if (!load && bus.out_ready) state_nxt = OUT_EMPTY;
         default:   state_nxt = OUT_EMPTY;
      endcase
   end

   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         state        <= OUT_EMPTY;
         cnt          <= '0;
         acc          <= '0;
         bus.out_data <= '0;
         bus.out_keep <= '0;
      end else begin
         state <= state_nxt;
         if (bus.rinc) begin
            if (cnt == LAST) begin
               bus.out_data <= {bus.rdata, acc};
               bus.out_keep <= '1;
               cnt          <= '0;
            end else begin
               acc[cnt] <= bus.rdata;
               cnt      <= cnt + CW'(1);
            end
         end
`ifdef FIFO_RDR_FLUSH_EN
         else if (flush_fire) begin
            bus.out_data <= {{DSIZE{1'b0}}, acc_masked};
            bus.out_keep <= LANES'(keep_mask(32'(cnt)));
            cnt          <= '0;
         end
`endif
      end
   end
endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer; FIFO_RDR_FLUSH_EN selects flush expectations.
module tb_fifo_rd_packer;
   logic rclk = 1'b0;
   logic rrst_n = 1'b0;

   fifo_rd_packer_if #(.DSIZE(8), .LANES(4)) bus ();

   fifo_rd_packer #(
      .DSIZE    (8),
      .LANES    (4),
      .IDLE_MAX (15)
   ) dut (
      .rclk   (rclk),
      .rrst_n (rrst_n),
      .bus    (bus)
   );

   always #5 rclk = ~rclk;

   logic [7:0]  q[$];
   logic [35:0] rx[$];
   int unsigned checks = 0, failures = 0;
   int unsigned pops = 0, valid_cycles = 0, viol = 0, cyc = 0;
   bit          gate_mode = 1'b0;
   logic        obs_rinc, obs_valid;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One rclk: inputs settle after the falling edge, decisions apply at the rising edge.
   task automatic cycle();
      logic pop_now;
      @(negedge rclk);
      bus.rempty = !((q.size() > 0) && (!gate_mode || cyc[0]));
      bus.rdata  = (q.size() > 0) ? q[0] : 8'h00;
      #1;
      pop_now   = bus.rinc;
      obs_rinc  = bus.rinc;
      obs_valid = bus.out_valid;
      if (bus.rinc && bus.rempty) viol++;
      if (bus.rinc) pops++;
      if (bus.out_valid) valid_cycles++;
      if (bus.out_valid && bus.out_ready) rx.push_back({bus.out_keep, bus.out_data});
      @(posedge rclk);
      if (pop_now && !bus.rempty) void'(q.pop_front());
      cyc++;
   endtask

   task automatic do_reset();
      @(negedge rclk);
      rrst_n     = 1'b0;
      bus.rempty = 1'b0;
      bus.rdata  = 8'h5A;
      #1;
      check_eq("rst_rinc",  bus.rinc, 0);
      check_eq("rst_valid", bus.out_valid, 0);
      check_eq("rst_data",  bus.out_data, 0);
      check_eq("rst_keep",  bus.out_keep, 0);
      repeat (2) @(negedge rclk);
      q.delete();
      rx.delete();
      bus.rempty   = 1'b1;
      rrst_n       = 1'b1;
      pops         = 0;
      valid_cycles = 0;
      viol         = 0;
      gate_mode    = 1'b0;
   endtask

   initial begin
      logic [5:0] exp_rinc;
      logic [5:0] exp_valid;
      bus.rempty    = 1'b1;
      bus.rdata     = '0;
      bus.out_ready = 1'b1;

      // single word, cycle-exact rinc/out_valid
      do_reset();
      q = '{8'h11, 8'h22, 8'h33, 8'h44};
      exp_rinc  = 6'b001111;
      exp_valid = 6'b010000;
      for (int i = 0; i < 6; i++) begin
         cycle();
         check_eq($sformatf("t1_rinc%0d", i), obs_rinc, exp_rinc[i]);
         check_eq($sformatf("t1_valid%0d", i), obs_valid, exp_valid[i]);
      end
      check_eq("t1_nwords", rx.size(), 1);
      if (rx.size() >= 1) check_eq("t1_word", rx[0], {4'hF, 32'h44332211});

      // streaming two words
      do_reset();
      for (int i = 1; i <= 8; i++) q.push_back(8'(i));
      for (int i = 0; i < 8; i++) begin
         cycle();
         check_eq($sformatf("t2_rinc%0d", i), obs_rinc, 1);
      end
      repeat (4) cycle();
      check_eq("t2_pops", pops, 8);
      check_eq("t2_nwords", rx.size(), 2);
      if (rx.size() >= 2) begin
         check_eq("t2_w0", rx[0], {4'hF, 32'h04030201});
         check_eq("t2_w1", rx[1], {4'hF, 32'h08070605});
      end

      // back-pressure
      do_reset();
      bus.out_ready = 1'b0;
      for (int i = 1; i <= 8; i++) q.push_back(8'(i));
      repeat (12) cycle();
      #1;
      check_eq("t3_pops", pops, 7);
      check_eq("t3_rinc_stall", obs_rinc, 0);
      check_eq("t3_hold_valid", bus.out_valid, 1);
      check_eq("t3_hold_data", bus.out_data, 32'h04030201);
      check_eq("t3_hold_keep", bus.out_keep, 4'hF);
      bus.out_ready = 1'b1;
      cycle();
      #1;
      check_eq("t3_hs_rinc", obs_rinc, 1);
      check_eq("t3_hs_valid", bus.out_valid, 1);
      check_eq("t3_hs_data", bus.out_data, 32'h08070605);
      repeat (3) cycle();
      check_eq("t3_nwords", rx.size(), 2);
      if (rx.size() >= 2) begin
         check_eq("t3_w0", rx[0], {4'hF, 32'h04030201});
         check_eq("t3_w1", rx[1], {4'hF, 32'h08070605});
      end

      // rempty toggling
      do_reset();
      gate_mode = 1'b1;
      for (int i = 0; i < 8; i++) q.push_back(8'hA0 + 8'(i));
      repeat (30) cycle();
      check_eq("t4_viol", viol, 0);
      check_eq("t4_pops", pops, 8);
      check_eq("t4_nwords", rx.size(), 2);
      if (rx.size() >= 2) begin
         check_eq("t4_w0", rx[0], {4'hF, 32'hA3A2A1A0});
         check_eq("t4_w1", rx[1], {4'hF, 32'hA7A6A5A4});
      end

      // partial word followed by a long empty stretch
      do_reset();
      q = '{8'hAA, 8'hBB};
      repeat (40) cycle();
      check_eq("t5_pops", pops, 2);
`ifdef FIFO_RDR_FLUSH_EN
      check_eq("t5_nwords", rx.size(), 1);
      if (rx.size() >= 1) check_eq("t5_flush", rx[0], {4'h3, 32'h0000BBAA});
`else
      check_eq("t5_nwords", rx.size(), 0);
      check_eq("t5_valid_cycles", valid_cycles, 0);
`endif

      // reset mid-word discards partial entries
      do_reset();
      q = '{8'h51, 8'h52};
      repeat (4) cycle();
      check_eq("t6_pre_pops", pops, 2);
      check_eq("t6_pre_valid", valid_cycles, 0);
      do_reset();
      repeat (4) cycle();
      check_eq("t6_post_valid", valid_cycles, 0);
      q = '{8'h61, 8'h62, 8'h63, 8'h64};
      repeat (8) cycle();
      check_eq("t6_nwords", rx.size(), 1);
      if (rx.size() >= 1) check_eq("t6_word", rx[0], {4'hF, 32'h64636261});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/fifo_rd_packer.md
# fifo_rd_packer

Read-side consumer for the team's asynchronous FIFO. It lives in the read clock domain, pops DSIZE-bit entries through the FIFO's show-ahead read port (rdata, rempty, rinc), and packs LANES consecutive entries into one wide word on a valid/ready output stream. Typical use: 8-bit FIFO bytes become 32-bit words for a downstream bus master.

## Interface
Parameters:
- DSIZE, 8, width of one FIFO entry (one lane).
- LANES, 4, entries per output word; power of two, at least 2.
- IDLE_MAX, 15, empty cycles before a partial-word flush; used only with FIFO_RDR_FLUSH_EN; at least 1.

Ports (one clock; reset is asynchronous, active-low):
- rclk  in  1  read-domain clock, rising edge.
- rrst_n  in  1  asynchronous active-low reset.
- rempty  in  1  FIFO empty flag, already synchronised to rclk.
- rdata  in  DSIZE  FIFO head entry; valid whenever rempty=0.
- rinc  out  1  pop strobe; the FIFO advances at the rclk edge where rinc=1 and rempty=0.
- out_valid  out  1  out_data/out_keep hold a word.
- out_ready  in  1  downstream accepts the word.
- out_data  out  DSIZE*LANES  packed word; lane 0 is bits [DSIZE-1:0] and holds the oldest entry.
- out_keep  out  LANES  per-lane valid mask.

## Operation
- Datapath: accumulation register acc (LANES-1 lanes), lane counter cnt (log2(LANES) bits), output register (out_data, out_keep, out_valid).
- Output FSM states:
  - OUT_EMPTY: out_valid=0.
  - OUT_FULL: out_valid=1.
  - OUT_FULL goes to OUT_EMPTY on out_valid&&out_ready unless a new word loads in the same cycle.
- Pop rule (combinational): rinc = rrst_n && !rempty && !(cnt==LANES-1 && out_valid && !out_ready).
- Capture when cnt<LANES-1 and rinc=1:
  - acc[cnt] <= rdata.
  - cnt <= cnt+1.
- Final capture when cnt==LANES-1 and rinc=1:
  - out_data <= {rdata, acc}.
  - out_keep <= all ones.
  - out_valid <= 1.
  - cnt <= 0 (wrap).
- Simultaneous handshake and final capture: the new word loads, out_valid stays 1, nothing is lost or duplicated.
- out_data and out_keep are stable while out_valid && !out_ready.
- rinc never asserts while rempty=1.
- The block never pops more entries than it can store.

## Timing
- Reset values: out_valid=0, out_data=0, out_keep=0, cnt=0, acc=0, idle counter=0. rinc=0 while rrst_n=0.
- Latency: the word is valid one rclk after the pop of its last entry.
- Throughput: one entry per cycle sustained when out_ready=1. One word every LANES cycles.
- Back-pressure: rinc drops only in the final-lane position, so up to LANES-1 entries are buffered during a stall.
- Reset mid-word: partially packed entries are discarded. No out_valid pulse is produced.

## Configuration
- FIFO_RDR_FLUSH_EN defined:
  - An idle counter increments every cycle with cnt>0 && rempty=1. It clears on any pop and saturates at IDLE_MAX.
  - When it reaches IDLE_MAX and out_valid=0 (or out_ready=1), acc loads to out_data. Unused lanes are zero.
  - out_keep gets its low cnt bits set. cnt and the idle counter clear.
  - If the output register is busy, the flush waits, with the counter held at IDLE_MAX.
  - A pop that arrives in the same cycle as the flush takes priority. The flush is cancelled.
- FIFO_RDR_FLUSH_EN not defined:
  - No idle counter is built.
  - Partial words wait indefinitely.
  - out_keep is all ones whenever out_valid=1.

## Structure
- Package fifo_rd_pkg:
  - function lane_cnt_w(LANES) returning log2 width.
  - typedef enum {OUT_EMPTY, OUT_FULL} out_state_t.
  - keep_mask(cnt) function producing a low-bits-set mask.
- Sub-module fifo_rd_idle_timer:
  - Saturating counter with clear and expire outputs.
  - Instantiated only under FIFO_RDR_FLUSH_EN.

## Test plan
- Reset, then the FIFO holds 0x11,0x22,0x33,0x44 with out_ready=1 -> rinc high 4 cycles. One cycle later out_data=0x44332211, out_keep=4'hF, single-cycle out_valid.
- Streaming 8 entries 0x01..0x08, out_ready=1 -> words 0x04030201 then 0x08070605 back-to-back. rinc continuous, no gaps.
- out_ready=0 with 8 entries available -> first word held. rinc stops after 7 pops (cnt=3). Raising out_ready pops the 8th entry and the second word loads in the handshake cycle.
- rempty toggling every cycle -> correct packing order. rinc never asserts while rempty=1.
- With FIFO_RDR_FLUSH_EN and IDLE_MAX=15: 0xAA,0xBB then empty -> 15 cycles later out_data=0x0000BBAA, out_keep=4'h3. Without the macro, no output.
- rrst_n pulsed low after 2 of 4 entries -> out_valid stays 0. The next 4 entries form a clean word starting at lane 0.
